// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave front end for the SUMP command/readback path.
// Synchronises the SPI pins, assembles opcode+opdata commands and streams a byte FIFO on miso.
module spi_slave_core #(
  parameter int unsigned CPOL         = 0,
  parameter int unsigned CPHA         = 0,
  parameter int unsigned OPDATA_BYTES = 4,
  parameter int unsigned SEND_BYTES   = 4,
  parameter int unsigned TXFIFO_DEPTH = 16
) (
  input  logic                              clock,
  input  logic                              extReset_n,
  input  logic                              sclk,
  input  logic                              cs,
  input  logic                              mosi,
  output logic                              miso,
  input  logic                              send,
  input  logic [8*SEND_BYTES-1:0]           send_data,
  input  logic [SEND_BYTES-1:0]             send_valid,
  output logic [8+8*OPDATA_BYTES-1:0]       cmd,
  output logic                              execute,
  output logic                              busy,
  output logic [$clog2(TXFIFO_DEPTH):0]     tx_level,
  output logic                              overflow,
  output logic                              underrun
);

  localparam int unsigned AW  = $clog2(TXFIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned LW  = $clog2(SEND_BYTES + 1);
  localparam int unsigned NW  = (OPDATA_BYTES > 1) ? $clog2(OPDATA_BYTES) : 1;
  localparam int unsigned ODW = 8 * OPDATA_BYTES;
  localparam logic IDLE_LVL   = 1'(CPOL);
  localparam logic CPHA_L     = 1'(CPHA);

  typedef enum logic {S_IDLE, S_DATA} state_t;

  logic          sclk_m, sclk_s, sclk_p, cs_m, cs_s, cs_p, mosi_m, mosi_s;
  logic          sclk_edge, lead, trail, sample_e, shift_e, byte_end, load, shift;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_sr, rx_byte, tx_sr;
  logic          byte_valid, tx_act;
  logic [7:0]    mem [TXFIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] lane_off [SEND_BYTES];
  logic [LW-1:0] k;
  logic [CW-1:0] free;
  logic          fits, wr_en, ovf, fifo_empty, pop;
  state_t        state;
  logic [NW-1:0] n;
  logic [7:0]    opcode;
  logic [ODW-1:0] opdata, opdata_next;

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      sclk_m <= IDLE_LVL;
      sclk_s <= IDLE_LVL;
      sclk_p <= IDLE_LVL;
      cs_m   <= 1'b0;
      cs_s   <= 1'b0;
      cs_p   <= 1'b0;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_p <= sclk_s;
      cs_m   <= cs;
      cs_s   <= cs_m;
      cs_p   <= cs_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  // The shift edge right after a load is skipped so the freshly loaded MSB stays on miso
  always_comb begin
    sclk_edge = sclk_s ^ sclk_p;
    lead      = sclk_edge & (sclk_p == IDLE_LVL);
    trail     = sclk_edge & (sclk_s == IDLE_LVL);
    sample_e  = ~cs_s & (CPHA_L ? trail : lead);
    shift_e   = ~cs_s & (CPHA_L ? lead : trail);
    byte_end  = sample_e & (bit_cnt == 3'd7);
    load      = CPHA_L ? (shift_e & (bit_cnt == 3'd0)) : ((cs_p & ~cs_s) | byte_end);
    shift     = shift_e & (bit_cnt != 3'd0);
  end

  // Compact the valid lanes: each lane's FIFO offset is the count of valid lanes below it
  always_comb begin
    k = '0;
    for (int i = 0; i < SEND_BYTES; i++) begin
      lane_off[i] = k;
      k = k + LW'(send_valid[i]);
    end
    free       = CW'(TXFIFO_DEPTH) - tx_level;
    fits       = CW'(k) <= free;
    wr_en      = send & (k != '0) & fits;
    ovf        = send & ~fits;
    fifo_empty = (tx_level == '0);
    pop        = load & ~fifo_empty;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < SEND_BYTES; i++)
      if (wr_en && send_valid[i]) mem[wr_ptr + AW'(lane_off[i])] <= send_data[8*i +: 8];
  end

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_level <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= ovf;
      if (wr_en) wr_ptr <= wr_ptr + AW'(k);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      tx_level <= tx_level + (wr_en ? CW'(k) : CW'(0)) - CW'(pop);
    end
  end

  // Bit-level receive and transmit shifters; cs high discards any partial byte
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      bit_cnt    <= '0;
      rx_sr      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      tx_sr      <= '0;
      tx_act     <= 1'b0;
      underrun   <= 1'b0;
      busy       <= 1'b0;
      miso       <= 1'b0;
    end else begin
      byte_valid <= byte_end;
      underrun   <= load & fifo_empty;
      busy       <= (tx_level != '0) | tx_act;
      miso       <= ~cs_s & tx_sr[7];
      if (cs_s) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
        tx_sr   <= '0;
        tx_act  <= 1'b0;
      end else begin
        if (sample_e) begin
          rx_sr   <= {rx_sr[6:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_end) begin
          rx_byte <= {rx_sr[6:0], mosi_s};
          tx_act  <= 1'b0;
        end
        if (load) begin
          tx_sr  <= fifo_empty ? 8'h00 : mem[rd_ptr];
          tx_act <= ~fifo_empty;
        end else if (shift) begin
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    opdata_next = opdata;
    opdata_next[{n, 3'b000} +: 8] = rx_byte;
  end

  // Command assembler: short opcodes execute alone, long ones collect opdata LSB byte first
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      state   <= S_IDLE;
      n       <= '0;
      opcode  <= '0;
      opdata  <= '0;
      cmd     <= '0;
      execute <= 1'b0;
    end else begin
      execute <= 1'b0;
      if (byte_valid) begin
        case (state)
          S_IDLE: begin
            if (rx_byte[7]) begin
              opcode <= rx_byte;
              n      <= '0;
              opdata <= '0;
              state  <= S_DATA;
            end else begin
              cmd     <= {ODW'(0), rx_byte};
              execute <= 1'b1;
            end
          end
          S_DATA: begin
            opdata <= opdata_next;
            if (n == NW'(OPDATA_BYTES - 1)) begin
              cmd     <= {opdata_next, opcode};
              execute <= 1'b1;
              state   <= S_IDLE;
            end else begin
              n <= n + NW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      if (cs_s) state <= S_IDLE;
    end
  end

endmodule
